// File: rtl/arm7tdmi_cp_responder_pkg.sv
// Shared types for the ARM7TDMI coprocessor responder: modes, coprocessor ops,
// responder states, CDP opcodes and instruction field positions.
package arm7tdmi_cp_responder_pkg;

  typedef enum logic [4:0] {
    MODE_USER       = 5'b10000,
    MODE_FIQ        = 5'b10001,
    MODE_IRQ        = 5'b10010,
    MODE_SUPERVISOR = 5'b10011,
    MODE_ABORT      = 5'b10111,
    MODE_UNDEF      = 5'b11011,
    MODE_SYSTEM     = 5'b11111
  } processor_mode_t;

  typedef enum logic [2:0] {
    CP_OP_NONE = 3'd0,
    CP_OP_CDP  = 3'd1,
    CP_OP_MCR  = 3'd2,
    CP_OP_MRC  = 3'd3,
    CP_OP_LDC  = 3'd4,
    CP_OP_STC  = 3'd5
  } cp_op_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CDP_BUSY  = 3'd1,
    ST_MCR_WAIT  = 3'd2,
    ST_MRC_DRIVE = 3'd3,
    ST_LDC_XFER  = 3'd4,
    ST_STC_XFER  = 3'd5,
    ST_DONE      = 3'd6
  } cp_state_t;

  localparam logic [3:0] CP_OPC_MOV = 4'd0;
  localparam logic [3:0] CP_OPC_ADD = 4'd1;
  localparam logic [3:0] CP_OPC_SUB = 4'd2;
  localparam logic [3:0] CP_OPC_EOR = 4'd3;

  localparam int INSTR_CPNUM_LSB = 8;
  localparam int INSTR_CRN_LSB   = 16;
  localparam int INSTR_CRD_LSB   = 12;
  localparam int INSTR_CRM_LSB   = 0;
  localparam int INSTR_OPC1_LSB  = 20;
  localparam int INSTR_L_BIT     = 20;
  localparam int INSTR_N_BIT     = 22;
  localparam int INSTR_RT_BIT    = 4;

  function automatic logic [31:0] cdp_alu(input logic [3:0] opc1,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (opc1)
      CP_OPC_MOV: r = b;
      CP_OPC_ADD: r = a + b;
      CP_OPC_SUB: r = a - b;
      CP_OPC_EOR: r = a ^ b;
      default:    r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arm7tdmi_cp_responder_if.sv
// Core <-> coprocessor handshake bundle; master is the core, slave the responder.
interface arm7tdmi_cp_responder_if;
  import arm7tdmi_cp_responder_pkg::*;

  logic            cpi;
  logic [31:0]     cp_instr;
  processor_mode_t cp_mode;
  logic            cpa;
  logic            cpb;
  logic            cp_done;
  logic [31:0]     core_wdata;
  logic            core_wvalid;
  logic [31:0]     cp_rdata;
  logic            cp_rvalid;
  logic            cp_rready;
  logic            cp_last;

  modport master (
    output cpi, cp_instr, cp_mode, core_wdata, core_wvalid, cp_rready,
    input  cpa, cpb, cp_done, cp_rdata, cp_rvalid, cp_last
  );

  modport slave (
    input  cpi, cp_instr, cp_mode, core_wdata, core_wvalid, cp_rready,
    output cpa, cpb, cp_done, cp_rdata, cp_rvalid, cp_last
  );
endinterface

// File: rtl/arm7tdmi_cp_decode.sv
// Combinational decode of a coprocessor instruction into op, fields and absent flag.
// ARM7TDMI_CP_PRIV_CHECK_EN: user-mode instructions are reported absent.
module arm7tdmi_cp_decode
  import arm7tdmi_cp_responder_pkg::*;
#(
  parameter logic [3:0] CP_NUM = 4'd7
) (
  input  logic [31:0]     instr,
  input  processor_mode_t cp_mode,
  output cp_op_t          op,
  output logic            absent,
  output logic [3:0]      crn,
  output logic [3:0]      crd,
  output logic [3:0]      crm,
  output logic [3:0]      opc1,
  output logic            n_bit
);

  logic priv_fault_s;
  logic unused_bits_s;

`ifdef ARM7TDMI_CP_PRIV_CHECK_EN
  assign priv_fault_s = (cp_mode == MODE_USER);
`else
  logic unused_mode_s;
  assign unused_mode_s = ^cp_mode;
  assign priv_fault_s  = 1'b0;
`endif

  assign unused_bits_s = ^{instr[31:28], instr[7:5]};

  assign crn   = instr[INSTR_CRN_LSB  +: 4];
  assign crd   = instr[INSTR_CRD_LSB  +: 4];
  assign crm   = instr[INSTR_CRM_LSB  +: 4];
  assign opc1  = instr[INSTR_OPC1_LSB +: 4];
  assign n_bit = instr[INSTR_N_BIT];

  // Classify the encoding, then fold every reason to refuse into one flag.
  always_comb begin
    op = CP_OP_NONE;
    if (instr[27:24] == 4'b1110) begin
      if (!instr[INSTR_RT_BIT]) begin
        op = CP_OP_CDP;
      end else if (instr[INSTR_L_BIT]) begin
        op = CP_OP_MRC;
      end else begin
        op = CP_OP_MCR;
      end
    end else if (instr[27:25] == 3'b110) begin
      op = instr[INSTR_L_BIT] ? CP_OP_LDC : CP_OP_STC;
    end else begin
      op = CP_OP_NONE;
    end

    absent = (op == CP_OP_NONE)
          || (instr[INSTR_CPNUM_LSB +: 4] != CP_NUM)
          || ((op == CP_OP_CDP) && (opc1 > CP_OPC_EOR))
          || priv_fault_s;
  end

endmodule

// File: rtl/arm7tdmi_cp_responder.sv
// ARM7TDMI coprocessor responder: handshake FSM, transfer counters and CR0-CR15.
// ARM7TDMI_CP_PRIV_CHECK_EN (see decode) rejects user-mode instructions.
module arm7tdmi_cp_responder
  import arm7tdmi_cp_responder_pkg::*;
#(
  parameter logic [3:0] CP_NUM          = 4'd7,
  parameter int         CDP_BUSY_CYCLES = 3,
  parameter int         LONG_XFER_WORDS = 4
) (
  input logic                     clk,
  input logic                     rst,
  arm7tdmi_cp_responder_if.slave  cp
);

  localparam logic [7:0] BUSY_INIT  = 8'(CDP_BUSY_CYCLES);
  localparam logic [4:0] WORDS_LONG = 5'(LONG_XFER_WORDS);

  cp_op_t      op_s;
  logic        absent_s;
  logic [3:0]  crn_s, crd_s, crm_s, opc1_s;
  logic        n_bit_s;
  logic [4:0]  words_s;

  cp_state_t   state_r;
  logic [31:0] cr_r [16];
  logic [3:0]  crd_r, crn_r, crm_r, opc1_r, idx_r;
  logic [4:0]  remain_r;
  logic [7:0]  busy_cnt_r;
  logic        cpa_r, cpb_r, done_r, rvalid_r, last_r;
  logic [31:0] rdata_r;

  arm7tdmi_cp_decode #(.CP_NUM(CP_NUM)) u_decode (
    .instr   (cp.cp_instr),
    .cp_mode (cp.cp_mode),
    .op      (op_s),
    .absent  (absent_s),
    .crn     (crn_s),
    .crd     (crd_s),
    .crm     (crm_s),
    .opc1    (opc1_s),
    .n_bit   (n_bit_s)
  );

  assign words_s = n_bit_s ? WORDS_LONG : 5'd1;

  // Handshake FSM with registered outputs; the register file shares this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cpa_r      <= 1'b0;
      cpb_r      <= 1'b0;
      done_r     <= 1'b0;
      rvalid_r   <= 1'b0;
      last_r     <= 1'b0;
      rdata_r    <= 32'd0;
      crd_r      <= 4'd0;
      crn_r      <= 4'd0;
      crm_r      <= 4'd0;
      opc1_r     <= 4'd0;
      idx_r      <= 4'd0;
      remain_r   <= 5'd0;
      busy_cnt_r <= 8'd0;
      for (int i = 0; i < 16; i++) begin
        cr_r[i] <= 32'd0;
      end
    end else begin
      cpa_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cp.cpi) begin
            crd_r  <= crd_s;
            crn_r  <= crn_s;
            crm_r  <= crm_s;
            opc1_r <= opc1_s;
            idx_r  <= crd_s;
            if (absent_s) begin
              cpa_r <= 1'b1;
            end else begin
              case (op_s)
                CP_OP_CDP: begin
                  if (BUSY_INIT == 8'd0) begin
                    cr_r[crd_s] <= cdp_alu(opc1_s, cr_r[crn_s], cr_r[crm_s]);
                    done_r      <= 1'b1;
                    state_r     <= ST_DONE;
                  end else begin
                    cpb_r      <= 1'b1;
                    busy_cnt_r <= BUSY_INIT;
                    state_r    <= ST_CDP_BUSY;
                  end
                end
                CP_OP_MCR: begin
                  cpb_r   <= 1'b1;
                  state_r <= ST_MCR_WAIT;
                end
                CP_OP_MRC: begin
                  rvalid_r <= 1'b1;
                  rdata_r  <= cr_r[crn_s];
                  state_r  <= ST_MRC_DRIVE;
                end
                CP_OP_LDC: begin
                  remain_r <= words_s;
                  last_r   <= (words_s == 5'd1);
                  state_r  <= ST_LDC_XFER;
                end
                CP_OP_STC: begin
                  remain_r <= words_s;
                  last_r   <= (words_s == 5'd1);
                  rvalid_r <= 1'b1;
                  rdata_r  <= cr_r[crd_s];
                  state_r  <= ST_STC_XFER;
                end
                default: state_r <= ST_IDLE;
              endcase
            end
          end
        end
        ST_CDP_BUSY: begin
          if (busy_cnt_r <= 8'd1) begin
            cr_r[crd_r] <= cdp_alu(opc1_r, cr_r[crn_r], cr_r[crm_r]);
            cpb_r       <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            busy_cnt_r <= busy_cnt_r - 8'd1;
          end
        end
        ST_MCR_WAIT: begin
          if (cp.core_wvalid) begin
            cr_r[crn_r] <= cp.core_wdata;
            cpb_r       <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_MRC_DRIVE: begin
          if (cp.cp_rready) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end
        end
        ST_LDC_XFER: begin
          if (cp.core_wvalid) begin
            cr_r[idx_r] <= cp.core_wdata;
            if (remain_r == 5'd1) begin
              last_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              idx_r    <= idx_r + 4'd1;
              remain_r <= remain_r - 5'd1;
              last_r   <= (remain_r == 5'd2);
            end
          end
        end
        ST_STC_XFER: begin
          if (cp.cp_rready) begin
            if (remain_r == 5'd1) begin
              rvalid_r <= 1'b0;
              rdata_r  <= 32'd0;
              last_r   <= 1'b0;
              done_r   <= 1'b1;
              state_r  <= ST_DONE;
            end else begin
              // The 4-bit index wraps CR15 -> CR0 on its own.
              idx_r    <= idx_r + 4'd1;
              rdata_r  <= cr_r[idx_r + 4'd1];
              remain_r <= remain_r - 5'd1;
              last_r   <= (remain_r == 5'd2);
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign cp.cpa       = cpa_r;
  assign cp.cpb       = cpb_r;
  assign cp.cp_done   = done_r;
  assign cp.cp_rdata  = rdata_r;
  assign cp.cp_rvalid = rvalid_r;
  assign cp.cp_last   = last_r;

endmodule

// File: tb/tb_arm7tdmi_cp_responder.sv
// Scoreboard bench for arm7tdmi_cp_responder: read data expected from a bench-side CR model.
module tb_arm7tdmi_cp_responder;
  import arm7tdmi_cp_responder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arm7tdmi_cp_responder_if cp_bus ();

  arm7tdmi_cp_responder #(
    .CP_NUM(4'd7), .CDP_BUSY_CYCLES(3), .LONG_XFER_WORDS(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cp  (cp_bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_cr [16];
  logic [31:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_cdp(input logic [3:0] opc1, input logic [3:0] crn,
                                          input logic [3:0] crd, input logic [3:0] crm,
                                          input logic [3:0] cpn);
    return {4'hE, 4'hE, opc1, crn, crd, cpn, 3'b000, 1'b0, crm};
  endfunction

  function automatic logic [31:0] enc_rt(input logic l, input logic [3:0] crn, input logic [3:0] cpn);
    return {4'hE, 4'hE, 3'b000, l, crn, 4'h0, cpn, 3'b000, 1'b1, 4'h0};
  endfunction

  function automatic logic [31:0] enc_mem(input logic l, input logic n, input logic [3:0] crd);
    return {4'hE, 3'b110, 1'b1, 1'b1, n, 1'b0, l, 4'h0, crd, 4'd7, 8'h00};
  endfunction

  task automatic issue(input logic [31:0] instr, input processor_mode_t mode);
    cp_bus.cpi      = 1'b1;
    cp_bus.cp_instr = instr;
    cp_bus.cp_mode  = mode;
    step();
    cp_bus.cpi      = 1'b0;
  endtask

  task automatic do_mcr(input logic [3:0] crn, input logic [31:0] data);
    issue(enc_rt(1'b0, crn, 4'd7), MODE_SUPERVISOR);
    check_val("mcr_cpb", {31'd0, cp_bus.cpb}, 32'd1);
    step();
    check_val("mcr_cpb_hold", {31'd0, cp_bus.cpb}, 32'd1);
    cp_bus.core_wvalid = 1'b1;
    cp_bus.core_wdata  = data;
    step();
    cp_bus.core_wvalid = 1'b0;
    check_val("mcr_done", {30'd0, cp_bus.cp_done, cp_bus.cpb}, 32'd2);
    model_cr[crn] = data;
    step();
  endtask

  // Pull words off the read channel, comparing each against the scoreboard head.
  task automatic recv_words(input int count, input int stall, input logic xfer, input string tag);
    for (int i = 0; i < count; i++) begin
      int t = 0;
      while (!cp_bus.cp_rvalid && t < 20) begin
        step();
        t++;
      end
      check_val({tag, "_rvalid"}, {31'd0, cp_bus.cp_rvalid}, 32'd1);
      for (int s = 0; s < stall; s++) begin
        step();
        check_val({tag, "_rvalid_stall"}, {31'd0, cp_bus.cp_rvalid}, 32'd1);
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s_sb: got %h expected none", tag, cp_bus.cp_rdata);
      end else begin
        check_val({tag, "_rdata"}, cp_bus.cp_rdata, exp_q.pop_front());
      end
      check_val({tag, "_last"}, {31'd0, cp_bus.cp_last}, {31'd0, xfer && (i == count - 1)});
      cp_bus.cp_rready = 1'b1;
      step();
      cp_bus.cp_rready = 1'b0;
    end
    check_val({tag, "_done"}, {30'd0, cp_bus.cp_done, cp_bus.cp_rvalid}, 32'd2);
    step();
  endtask

  task automatic do_mrc(input logic [3:0] crn, input string tag);
    issue(enc_rt(1'b1, crn, 4'd7), MODE_SUPERVISOR);
    exp_q.push_back(model_cr[crn]);
    recv_words(1, 1, 1'b0, tag);
  endtask

  task automatic do_cdp(input logic [3:0] opc1, input logic [3:0] crn,
                        input logic [3:0] crd, input logic [3:0] crm);
    int n = 0;
    issue(enc_cdp(opc1, crn, crd, crm, 4'd7), MODE_SUPERVISOR);
    while (cp_bus.cpb && n < 20) begin
      n++;
      step();
    end
    check_val("cdp_busy_cycles", n, 32'd3);
    check_val("cdp_done", {31'd0, cp_bus.cp_done}, 32'd1);
    case (opc1)
      4'd0:    model_cr[crd] = model_cr[crm];
      4'd1:    model_cr[crd] = model_cr[crn] + model_cr[crm];
      4'd2:    model_cr[crd] = model_cr[crn] - model_cr[crm];
      default: model_cr[crd] = model_cr[crn] ^ model_cr[crm];
    endcase
    step();
  endtask

  task automatic send_words(input logic [31:0] w [4], input int count, input string tag);
    for (int i = 0; i < count; i++) begin
      cp_bus.core_wvalid = 1'b1;
      cp_bus.core_wdata  = w[i];
      check_val({tag, "_last"}, {31'd0, cp_bus.cp_last}, {31'd0, i == count - 1});
      step();
      cp_bus.core_wvalid = 1'b0;
      if (i < count - 1) begin
        step();
      end
    end
    check_val({tag, "_done"}, {30'd0, cp_bus.cp_done, cp_bus.cpb}, 32'd2);
    step();
  endtask

  task automatic check_absent(input logic [31:0] instr, input processor_mode_t mode, input string tag);
    issue(instr, mode);
    check_val({tag, "_cpa"}, {29'd0, cp_bus.cpa, cp_bus.cpb, cp_bus.cp_rvalid}, 32'd4);
    step();
    check_val({tag, "_after"}, {30'd0, cp_bus.cpa, cp_bus.cp_done}, 32'd0);
  endtask

  logic [31:0] ldc_w [4];
  int          done_seen;

  initial begin
    rst                = 1'b1;
    cp_bus.cpi         = 1'b0;
    cp_bus.cp_instr    = 32'd0;
    cp_bus.cp_mode     = MODE_SUPERVISOR;
    cp_bus.core_wdata  = 32'd0;
    cp_bus.core_wvalid = 1'b0;
    cp_bus.cp_rready   = 1'b0;
    for (int i = 0; i < 16; i++) model_cr[i] = 32'd0;
    repeat (3) step();
    rst = 1'b0;
    check_val("reset_flags", {26'd0, cp_bus.cpa, cp_bus.cpb, cp_bus.cp_done,
              cp_bus.cp_rvalid, cp_bus.cp_last, 1'b0}, 32'd0);
    check_val("reset_rdata", cp_bus.cp_rdata, 32'd0);

    // MCR with a stray cpi while waiting, then MRC readback.
    issue(enc_rt(1'b0, 4'd3, 4'd7), MODE_SUPERVISOR);
    check_val("mcr3_cpb", {30'd0, cp_bus.cpa, cp_bus.cpb}, 32'd1);
    issue(enc_rt(1'b1, 4'd3, 4'd6), MODE_SUPERVISOR);
    check_val("busy_cpi_ignored", {30'd0, cp_bus.cpa, cp_bus.cpb}, 32'd1);
    cp_bus.core_wvalid = 1'b1;
    cp_bus.core_wdata  = 32'hDEADBEEF;
    step();
    cp_bus.core_wvalid = 1'b0;
    check_val("mcr3_done", {30'd0, cp_bus.cp_done, cp_bus.cpb}, 32'd2);
    model_cr[3] = 32'hDEADBEEF;
    step();
    check_val("done_pulse_width", {31'd0, cp_bus.cp_done}, 32'd0);
    issue(enc_rt(1'b1, 4'd3, 4'd7), MODE_SUPERVISOR);
    exp_q.push_back(32'hDEADBEEF);
    recv_words(1, 2, 1'b0, "mrc3");

    // CDP with modulo arithmetic.
    do_mcr(4'd1, 32'd5);
    do_mcr(4'd2, 32'hFFFFFFFE);
    do_cdp(4'd1, 4'd1, 4'd4, 4'd2);
    exp_q.push_back(32'd3);
    issue(enc_rt(1'b1, 4'd4, 4'd7), MODE_SUPERVISOR);
    recv_words(1, 0, 1'b0, "cdp_add");
    do_cdp(4'd2, 4'd1, 4'd5, 4'd2);
    do_cdp(4'd3, 4'd1, 4'd6, 4'd2);
    do_cdp(4'd0, 4'd1, 4'd7, 4'd3);
    do_mrc(4'd5, "cdp_sub");
    do_mrc(4'd6, "cdp_eor");
    do_mrc(4'd7, "cdp_mov");

    // Absent cases leave the register file alone.
    check_absent(enc_rt(1'b1, 4'd4, 4'd6), MODE_SUPERVISOR, "absent_cpnum");
    check_absent(enc_cdp(4'd7, 4'd1, 4'd4, 4'd2, 4'd7), MODE_SUPERVISOR, "absent_opc1");
    check_absent(32'hE0810002, MODE_SUPERVISOR, "absent_noncp");
    do_mrc(4'd4, "absent_cr4_kept");

    // LDC long with CR15 -> CR0 wrap, then STC of the same window with stalls.
    ldc_w[0] = 32'd1; ldc_w[1] = 32'd2; ldc_w[2] = 32'd3; ldc_w[3] = 32'd4;
    issue(enc_mem(1'b1, 1'b1, 4'd14), MODE_SUPERVISOR);
    check_val("ldc_cpb_low", {31'd0, cp_bus.cpb}, 32'd0);
    send_words(ldc_w, 4, "ldc_long");
    for (int i = 0; i < 4; i++) model_cr[(14 + i) % 16] = ldc_w[i];
    issue(enc_mem(1'b0, 1'b1, 4'd14), MODE_SUPERVISOR);
    for (int i = 0; i < 4; i++) exp_q.push_back(model_cr[(14 + i) % 16]);
    recv_words(4, 1, 1'b1, "stc_long");
    do_mrc(4'd1, "ldc_wrap_cr1");
    ldc_w[0] = 32'h12345678;
    issue(enc_mem(1'b1, 1'b0, 4'd9), MODE_SUPERVISOR);
    send_words(ldc_w, 1, "ldc_short");
    model_cr[9] = 32'h12345678;
    issue(enc_mem(1'b0, 1'b0, 4'd9), MODE_SUPERVISOR);
    exp_q.push_back(model_cr[9]);
    recv_words(1, 0, 1'b1, "stc_short");

    // Reset in the second busy cycle of a CDP aborts it.
    issue(enc_cdp(4'd0, 4'd0, 4'd10, 4'd3, 4'd7), MODE_SUPERVISOR);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_cr[i] = 32'd0;
    check_val("midrst_flags", {27'd0, cp_bus.cpa, cp_bus.cpb, cp_bus.cp_done,
              cp_bus.cp_rvalid, cp_bus.cp_last}, 32'd0);
    check_val("midrst_rdata", cp_bus.cp_rdata, 32'd0);
    done_seen = 0;
    repeat (5) begin
      step();
      if (cp_bus.cp_done) done_seen++;
    end
    check_val("midrst_no_done", done_seen, 32'd0);
    do_mrc(4'd10, "midrst_crd");
    do_mrc(4'd3, "midrst_cr3");

    // Mode sensitivity of MRC.
    do_mcr(4'd9, 32'hA5A55A5A);
    issue(enc_rt(1'b1, 4'd9, 4'd7), MODE_USER);
`ifdef ARM7TDMI_CP_PRIV_CHECK_EN
    check_val("priv_user_cpa", {30'd0, cp_bus.cpa, cp_bus.cp_rvalid}, 32'd2);
    step();
    do_mrc(4'd9, "priv_svc_mrc");
`else
    exp_q.push_back(model_cr[9]);
    recv_words(1, 0, 1'b0, "user_mrc");
`endif

    check_val("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
